// File: rtl/std_divmod_pkg.sv
// ============================================================================
//  Module      : std_divmod_pkg
//  Description : Shared types, constants and helpers for the iterative
//                divide/modulo unit (std_divmod_iter) and its sub-modules.
//                  state_t       - controller states
//                  DBZ_QUOTIENT  - quotient pattern returned on divide by zero
//                  abs_val()     - two's-complement magnitude helper
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package std_divmod_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widest operand the helper below supports; callers zero-extend into this
  // width and cast the result back down to their own width.
  localparam int ABS_MAX_WIDTH = 128;

  // Divide-by-zero quotient: all ones at any width after truncation.
  localparam logic [ABS_MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;

  // Magnitude of a two's-complement value whose sign the caller supplies.
  // Only the low bits matching the caller's width are meaningful, which is
  // exactly the modular negation of the caller's operand.
  function automatic logic [ABS_MAX_WIDTH-1:0] abs_val(
    input logic [ABS_MAX_WIDTH-1:0] value,
    input logic                     negative
  );
    return negative ? (~value + ABS_MAX_WIDTH'(1)) : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/std_lzc.sv
// ============================================================================
//  Module      : std_lzc
//  Description : Combinational leading-zero counter. Returns WIDTH when the
//                input is all zeros.
//  Ports       : value [WIDTH-1:0]        - input word
//                count [$clog2(WIDTH):0]  - number of leading zeros
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module std_lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]       value,
  output logic [$clog2(WIDTH):0] count
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Scan from LSB upward so the highest set bit is the last one to win.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) begin
        count = CW'(WIDTH - 1 - i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/std_divmod_iter.sv
// ============================================================================
//  Module      : std_divmod_iter
//  Description : Iterative radix-2 restoring divider producing quotient and
//                remainder of one operation, with run-time signed/unsigned
//                mode. Quotient truncates toward zero; remainder takes the
//                dividend's sign. Divide by zero returns an all-ones quotient
//                and the raw dividend as remainder, flagged by div_by_zero.
//  Config      : define STD_DIVMOD_EARLY_EXIT_EN to skip the dividend's
//                leading zeros (variable latency, identical results).
//  Ports       : clk          - clock, rising edge
//                reset        - asynchronous active-high reset
//                go           - level request, held until done is seen
//                is_signed    - two's-complement operands (sampled at start)
//                left         - dividend (sampled at start)
//                right        - divisor  (sampled at start)
//                quotient     - result quotient
//                remainder    - result remainder
//                div_by_zero  - set with the results when right was zero
//                done         - single-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module std_divmod_iter
  import std_divmod_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;

  // dvd holds the remaining dividend bits in its upper part while quotient
  // bits are shifted into its lower part; after the last step it is the
  // unsigned quotient.
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             sign_r;
  logic             dbz;

  logic             left_neg;
  logic             right_neg;
  logic [WIDTH-1:0] left_mag;
  logic [WIDTH-1:0] right_mag;
  logic             right_zero;
  logic [WIDTH-1:0] dvd_init;
  logic [CNT_W-1:0] cnt_init;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             trial_ok;

  assign left_neg   = is_signed & left[WIDTH-1];
  assign right_neg  = is_signed & right[WIDTH-1];
  assign left_mag   = WIDTH'(abs_val(ABS_MAX_WIDTH'(left),  left_neg));
  assign right_mag  = WIDTH'(abs_val(ABS_MAX_WIDTH'(right), right_neg));
  assign right_zero = (right == '0);

  // Remainder stays below the divisor, so WIDTH bits hold it between steps;
  // the extra bit is only needed for the shifted trial value.
  assign shifted  = {rem, dvd[WIDTH-1]};
  assign trial    = shifted - {1'b0, dsr};
  assign trial_ok = ~trial[WIDTH];

`ifdef STD_DIVMOD_EARLY_EXIT_EN
  logic [$clog2(WIDTH):0] lz;

  std_lzc #(
    .WIDTH (WIDTH)
  ) u_lzc (
    .value (left_mag),
    .count (lz)
  );

  // Leading zeros of the dividend produce only zero quotient bits and leave
  // the partial remainder at zero, so they are shifted out up front. A zero
  // dividend still takes one step.
  assign dvd_init = left_mag << lz;
  assign cnt_init = (int'(lz) >= WIDTH) ? CNT_W'(1) : CNT_W'(WIDTH - int'(lz));
`else
  assign dvd_init = left_mag;
  assign cnt_init = CNT_W'(WIDTH);
`endif

  assign done = (state == DONE);

  // --------------------------------------------------------------------------
  // Controller
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (go) begin
          state_next = right_zero ? FIXUP : CALC;
        end
      end
      CALC: begin
        if (!go) begin
          state_next = IDLE;
        end else if (cnt == CNT_W'(1)) begin
          state_next = FIXUP;
        end
      end
      FIXUP: begin
        state_next = go ? DONE : IDLE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd         <= '0;
      rem         <= '0;
      dsr         <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz         <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            rem    <= '0;
            dsr    <= right_mag;
            cnt    <= cnt_init;
            dbz    <= right_zero;
            // Divide by zero reports the raw dividend, so keep it unsigned
            // and unshifted.
            dvd    <= right_zero ? left : dvd_init;
            sign_q <= ~right_zero & (left_neg ^ right_neg);
            sign_r <= ~right_zero & left_neg;
          end
        end
        CALC: begin
          if (go) begin
            rem <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], trial_ok};
            cnt <= cnt - CNT_W'(1);
          end
        end
        FIXUP: begin
          if (go) begin
            if (dbz) begin
              quotient    <= WIDTH'(DBZ_QUOTIENT);
              remainder   <= dvd;
              div_by_zero <= 1'b1;
            end else begin
              quotient    <= sign_q ? -dvd : dvd;
              remainder   <= sign_r ? -rem : rem;
              div_by_zero <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/std_divmod_iter.md
Name: std_divmod_iter

Overview:
- Parametrised iterative radix-2 divider that returns both quotient and remainder from one operation.
- Supports run-time signed/unsigned mode and defined divide-by-zero and overflow results.
- Asynchronous reset.
- Successor to the separate fixed-function div/mod pipes; used by the compiler backend wherever a div and mod share operands, so one unit serves both.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 2).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- go  input  1  level request; held high until done is observed.
- is_signed  input  1  1 = two's-complement operands; sampled at start.
- left  input  WIDTH  dividend; sampled at start.
- right  input  WIDTH  divisor; sampled at start.
- quotient  output  WIDTH  result quotient; valid from the done cycle until the next start.
- remainder  output  WIDTH  result remainder; same validity as quotient.
- div_by_zero  output  1  set with the results when right == 0.
- done  output  1  single-cycle pulse.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; quotient, remainder, div_by_zero, done = 0; all internal registers cleared.
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - When go=1, latch operands and mode ("start"), then go to CALC.
  - In signed mode, latch the magnitudes |left| and |right| and record sign_q = sign(left) XOR sign(right) and sign_r = sign(left).
  - Load iteration counter = WIDTH.
- CALC: one restoring step per cycle.
  - Partial remainder is WIDTH+1 bits: shift in the next dividend MSB.
  - Trial subtract the divisor magnitude; if the result is non-negative, keep it and set the quotient bit.
  - Counter decrements; go to FIXUP when counter reaches 1.
- FIXUP: apply signs.
  - Quotient is negated if sign_q; remainder is negated if sign_r (truncation toward zero, remainder takes the dividend's sign).
  - Register the outputs, then go to DONE.
- DONE:
  - done = 1 for exactly this cycle; then go to IDLE.
  - A new start requires go=1 while in IDLE, so at least one idle cycle separates operations.
- Latency: done is high in the cycle WIDTH+2 clocks after the first cycle go is seen high in IDLE.
- Divide by zero (right == 0): skip CALC and go directly to FIXUP.
  - quotient = all ones; remainder = left unmodified; div_by_zero = 1.
  - Latency is 2 cycles.
- Signed overflow (is_signed, left = most-negative value, right = -1): quotient = most-negative value, remainder = 0, div_by_zero = 0. The normal path yields this naturally; the bench checks it.
- Abort: if go falls while in CALC or FIXUP, return to IDLE next cycle.
  - done is not asserted; outputs keep their previous values.
- go high in the DONE cycle has no effect.
- left = 0: quotient = 0, remainder = 0, normal latency (unless the optional feature is enabled).
- Operand changes after start are ignored.
- Reset mid-operation: immediate return to reset values; no done.

Optional Feature:
- Macro: STD_DIVMOD_EARLY_EXIT_EN.
- When defined:
  - In IDLE, a leading-zero count lz of the dividend magnitude pre-shifts the dividend.
  - The counter is loaded with max(WIDTH - lz, 1), giving done at max(WIDTH - lz, 1) + 2 cycles.
  - Results are identical to the fixed-latency mode.
- When undefined: fixed WIDTH+2 latency; no LZC logic is synthesised.

Decomposition:
- Package std_divmod_pkg:
  - state enum type (IDLE, CALC, FIXUP, DONE);
  - localparam for the divide-by-zero quotient pattern (all ones);
  - function abs_val (two's-complement magnitude).
- Sub-module std_lzc:
  - parametrised by WIDTH; combinational leading-zero count, output width $clog2(WIDTH)+1.
  - Instantiated only under STD_DIVMOD_EARLY_EXIT_EN.

Test Plan:
- WIDTH=32, unsigned 100/7 -> quotient 14, remainder 2, done pulse exactly 34 cycles after go, single cycle.
- Signed -7/2 -> quotient -3 (0xFFFFFFFD), remainder -1; signed 7/-2 -> quotient -3, remainder 1; unsigned 0xFFFFFFF9/2 -> quotient 0x7FFFFFFC, remainder 1.
- right=0, left=0x1234 -> quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero=1, done 2 cycles after go; the next normal op clears div_by_zero.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero=0.
- go dropped at cycle 10 of CALC -> no done, outputs unchanged; reset asserted mid-CALC -> all outputs 0 immediately (asynchronously), FSM in IDLE.
- With STD_DIVMOD_EARLY_EXIT_EN, WIDTH=32, 5/3 -> quotient 1, remainder 2, done 5 cycles after go (lz=29); 0/9 -> quotient 0, remainder 0, done after 3 cycles.
